// File: rtl/selftrigger_channel_sequencer.sv
// ---------------------------------------------------------------------------
// selftrigger_channel_sequencer
//
// Per-channel controller for one self-trigger filter chain (baseline LPF,
// HPF, xcorr match, CFD). It walks the chain through flush, baseline
// settling, armed and dead-time phases. It also holds host configuration
// until a safe point, and turns the raw CFD trigger into one qualified
// pulse per event.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   ch_enable_req     host channel enable level
//   cfg_wr            strobe capturing cfg_threshold/cfg_selector/cfg_deadtime
//   cfg_ack           one-cycle pulse when the pending config becomes active
//   trig_in           raw trigger from the CFD
//   filt_enable       enable to the filter chain
//   filt_reset        reset to the filter chain
//   threshold_xc      active xcorr threshold
//   output_selector   active output selector
//   trig_out          qualified trigger pulse
//   armed             high while the channel accepts triggers
//   state             IDLE=0 FLUSH=1 SETTLE=2 ARMED=3 DEAD=4
//   trig_count        accepted triggers, wraps
//   veto_count        edges rejected in SETTLE/DEAD, saturates
// ---------------------------------------------------------------------------
module selftrigger_channel_sequencer #(
    parameter int unsigned FLUSH_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 4096,
    parameter logic [41:0] DEFAULT_THR   = 42'd0,
    parameter logic [15:0] DEFAULT_DEAD  = 16'd256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ch_enable_req,
    input  logic        cfg_wr,
    input  logic [41:0] cfg_threshold,
    input  logic [1:0]  cfg_selector,
    input  logic [15:0] cfg_deadtime,
    output logic        cfg_ack,
    input  logic        trig_in,
    output logic        filt_enable,
    output logic        filt_reset,
    output logic [41:0] threshold_xc,
    output logic [1:0]  output_selector,
    output logic        trig_out,
    output logic        armed,
    output logic [2:0]  state,
    output logic [31:0] trig_count,
    output logic [15:0] veto_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FLUSH  = 3'd1,
        S_SETTLE = 3'd2,
        S_ARMED  = 3'd3,
        S_DEAD   = 3'd4
    } stateT;

    stateT       state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        trigInD_q;
    logic        filtEnable_q, filtEnable_d;
    logic        filtReset_q, filtReset_d;
    logic        armed_q, armed_d;
    logic        trigOut_q, trigOut_d;
    logic        cfgAck_q, cfgAck_d;
    logic [41:0] thr_q, thr_d;
    logic [1:0]  sel_q, sel_d;
    logic [15:0] deadTime_q, deadTime_d;
    logic        pend_q, pend_d;
    logic [41:0] pendThr_q, pendThr_d;
    logic [1:0]  pendSel_q, pendSel_d;
    logic [15:0] pendDead_q, pendDead_d;
    logic [31:0] trigCount_q, trigCount_d;
    logic [15:0] vetoCount_q, vetoCount_d;

    logic        rise;
    logic        trigFire;
    logic        veto;
    logic        apply;
    logic [31:0] deadLoad;

    // All state lives here; reset drops any pending config along with everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 32'd0;
            trigInD_q    <= 1'b0;
            filtEnable_q <= 1'b0;
            filtReset_q  <= 1'b1;
            armed_q      <= 1'b0;
            trigOut_q    <= 1'b0;
            cfgAck_q     <= 1'b0;
            thr_q        <= DEFAULT_THR;
            sel_q        <= 2'b00;
            deadTime_q   <= DEFAULT_DEAD;
            pend_q       <= 1'b0;
            pendThr_q    <= 42'd0;
            pendSel_q    <= 2'b00;
            pendDead_q   <= 16'd0;
            trigCount_q  <= 32'd0;
            vetoCount_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            trigInD_q    <= trig_in;
            filtEnable_q <= filtEnable_d;
            filtReset_q  <= filtReset_d;
            armed_q      <= armed_d;
            trigOut_q    <= trigOut_d;
            cfgAck_q     <= cfgAck_d;
            thr_q        <= thr_d;
            sel_q        <= sel_d;
            deadTime_q   <= deadTime_d;
            pend_q       <= pend_d;
            pendThr_q    <= pendThr_d;
            pendSel_q    <= pendSel_d;
            pendDead_q   <= pendDead_d;
            trigCount_q  <= trigCount_d;
            vetoCount_q  <= vetoCount_d;
        end
    end

    // Phase sequencing. One shared down-counter times flush, settle and dead-time;
    // it is loaded with length-1 on entry and the phase ends when it reads zero.
    // A zero dead-time loads 0, giving one DEAD cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rise     = trig_in & ~trigInD_q;
        deadLoad = (deadTime_q == 16'd0) ? 32'd0 : {16'd0, deadTime_q - 16'd1};
        if (!ch_enable_req) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FLUSH;
                    cnt_d   = 32'(FLUSH_CYCLES - 1);
                end
                S_FLUSH: begin
                    if (cnt_q == 32'd0) begin
                        state_d = S_SETTLE;
                        cnt_d   = 32'(SETTLE_CYCLES - 1);
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == 32'd0) state_d = S_ARMED;
                    else                cnt_d   = cnt_q - 32'd1;
                end
                S_ARMED: begin
                    if (rise) begin
                        state_d = S_DEAD;
                        cnt_d   = deadLoad;
                    end
                end
                S_DEAD: begin
                    if (cnt_q == 32'd0) state_d = S_ARMED;
                    else                cnt_d   = cnt_q - 32'd1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output and datapath next values. Chain controls are decoded from the next
    // state so they change on the same edge as the state itself. A trigger in
    // ARMED wins over config apply, so the trigger sees the old threshold.
    always_comb begin
        trigFire     = ch_enable_req && (state_q == S_ARMED) && rise;
        veto         = ch_enable_req && ((state_q == S_SETTLE) || (state_q == S_DEAD)) && rise;
        apply        = pend_q && ((state_q == S_IDLE) || ((state_q == S_ARMED) && !rise));

        filtEnable_d = (state_d != S_IDLE);
        filtReset_d  = (state_d == S_IDLE) || (state_d == S_FLUSH);
        armed_d      = (state_d == S_ARMED);
        trigOut_d    = trigFire;
        cfgAck_d     = apply;

        thr_d        = apply ? pendThr_q  : thr_q;
        sel_d        = apply ? pendSel_q  : sel_q;
        deadTime_d   = apply ? pendDead_q : deadTime_q;

        // A write in the apply cycle re-arms pending with the new data.
        pend_d       = cfg_wr | (pend_q & ~apply);
        pendThr_d    = cfg_wr ? cfg_threshold : pendThr_q;
        pendSel_d    = cfg_wr ? cfg_selector  : pendSel_q;
        pendDead_d   = cfg_wr ? cfg_deadtime  : pendDead_q;

        trigCount_d  = trigFire ? (trigCount_q + 32'd1) : trigCount_q;
        vetoCount_d  = (veto && (vetoCount_q != 16'hFFFF)) ? (vetoCount_q + 16'd1) : vetoCount_q;
    end

    assign cfg_ack         = cfgAck_q;
    assign filt_enable     = filtEnable_q;
    assign filt_reset      = filtReset_q;
    assign threshold_xc    = thr_q;
    assign output_selector = sel_q;
    assign trig_out        = trigOut_q;
    assign armed           = armed_q;
    assign state           = state_q;
    assign trig_count      = trigCount_q;
    assign veto_count      = vetoCount_q;

endmodule

// File: tb/tb_selftrigger_channel_sequencer.sv
// ---------------------------------------------------------------------------
// tb_selftrigger_channel_sequencer
//
// Directed bench for selftrigger_channel_sequencer with SETTLE_CYCLES=16.
// A fixed timeline relative to the enable cycle drives the channel through
// the power-up sequence, several triggers and dead-times, deferred config,
// an enable drop and a reset. Every trig_out and cfg_ack pulse is matched
// against expectations queued when the stimulus was issued.
// ---------------------------------------------------------------------------
module tb_selftrigger_channel_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ch_enable_req;
    logic        cfg_wr;
    logic [41:0] cfg_threshold;
    logic [1:0]  cfg_selector;
    logic [15:0] cfg_deadtime;
    logic        cfg_ack;
    logic        trig_in;
    logic        filt_enable;
    logic        filt_reset;
    logic [41:0] threshold_xc;
    logic [1:0]  output_selector;
    logic        trig_out;
    logic        armed;
    logic [2:0]  state;
    logic [31:0] trig_count;
    logic [15:0] veto_count;

    localparam logic [41:0] THR_MAX = {42{1'b1}};

    typedef struct {
        int          cyc;
        logic [31:0] cnt;
        logic [41:0] thr;
        logic [1:0]  sel;
    } expT;

    expT trigQ[$];
    expT cfgQ[$];

    int  cyc   = 0;
    int  c0    = 0;
    int  tests = 0;
    int  fails = 0;
    bit  done  = 1'b0;

    selftrigger_channel_sequencer #(
        .FLUSH_CYCLES  (4),
        .SETTLE_CYCLES (16),
        .DEFAULT_THR   (42'd0),
        .DEFAULT_DEAD  (16'd256)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ch_enable_req   (ch_enable_req),
        .cfg_wr          (cfg_wr),
        .cfg_threshold   (cfg_threshold),
        .cfg_selector    (cfg_selector),
        .cfg_deadtime    (cfg_deadtime),
        .cfg_ack         (cfg_ack),
        .trig_in         (trig_in),
        .filt_enable     (filt_enable),
        .filt_reset      (filt_reset),
        .threshold_xc    (threshold_xc),
        .output_selector (output_selector),
        .trig_out        (trig_out),
        .armed           (armed),
        .state           (state),
        .trig_count      (trig_count),
        .veto_count      (veto_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, required %0h", name, cyc - c0, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic trg);
        ch_enable_req = en;
        trig_in       = trg;
    endtask

    task automatic writeCfg(input logic [41:0] thr, input logic [1:0] sel, input logic [15:0] dead);
        cfg_threshold = thr;
        cfg_selector  = sel;
        cfg_deadtime  = dead;
        cfg_wr        = 1'b1;
        @(negedge clk);
        cfg_wr        = 1'b0;
    endtask

    task automatic at(input int r);
        while (cyc < c0 + r) @(negedge clk);
    endtask

    task automatic pushTrig(input int r, input logic [31:0] cnt, input logic [41:0] thr, input logic [1:0] sel);
        expT e;
        e.cyc = c0 + r; e.cnt = cnt; e.thr = thr; e.sel = sel;
        trigQ.push_back(e);
    endtask

    task automatic pushCfg(input int r, input logic [31:0] cnt, input logic [41:0] thr, input logic [1:0] sel);
        expT e;
        e.cyc = c0 + r; e.cnt = cnt; e.thr = thr; e.sel = sel;
        cfgQ.push_back(e);
    endtask

    // Monitor: any pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        expT e;
        if (!done && trig_out === 1'b1) begin
            if (trigQ.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_trig_out at cycle %0d: trig_out=1, required 0", cyc - c0);
            end else begin
                e = trigQ.pop_front();
                checkOutput("trig_cycle", 64'(cyc - c0), 64'(e.cyc - c0));
                checkOutput("trig_count", 64'(trig_count), 64'(e.cnt));
                checkOutput("trig_threshold", 64'(threshold_xc), 64'(e.thr));
                checkOutput("trig_selector", 64'(output_selector), 64'(e.sel));
            end
        end
        if (!done && cfg_ack === 1'b1) begin
            if (cfgQ.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_cfg_ack at cycle %0d: cfg_ack=1, required 0", cyc - c0);
            end else begin
                e = cfgQ.pop_front();
                checkOutput("ack_cycle", 64'(cyc - c0), 64'(e.cyc - c0));
                checkOutput("ack_trig_count", 64'(trig_count), 64'(e.cnt));
                checkOutput("ack_threshold", 64'(threshold_xc), 64'(e.thr));
                checkOutput("ack_selector", 64'(output_selector), 64'(e.sel));
            end
        end
    end

    initial begin
        #20000;
        fails++;
        $display("[TB] FAIL watchdog: timeline did not complete, required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int nReset;
        int firstArmed;
        reset         = 1'b1;
        cfg_wr        = 1'b0;
        cfg_threshold = 42'd0;
        cfg_selector  = 2'd0;
        cfg_deadtime  = 16'd0;
        applyStimulus(1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // Reset state.
        checkOutput("rst_state", 64'(state), 64'd0);
        checkOutput("rst_filt_reset", 64'(filt_reset), 64'd1);
        checkOutput("rst_filt_enable", 64'(filt_enable), 64'd0);
        checkOutput("rst_threshold", 64'(threshold_xc), 64'd0);
        checkOutput("rst_counts", 64'({trig_count, veto_count}), 64'd0);

        // Power-up: 4 flush cycles, 16 settle cycles, one vetoed edge in SETTLE.
        c0     = cyc;
        reset  = 1'b0;
        applyStimulus(1'b1, 1'b0);
        nReset = 0;
        firstArmed = 0;
        for (int i = 1; i <= 21; i++) begin
            at(i);
            if (filt_reset === 1'b1) nReset++;
            if (armed === 1'b1 && firstArmed == 0) firstArmed = i;
            if (i == 10) applyStimulus(1'b1, 1'b1);
            if (i == 11) applyStimulus(1'b1, 1'b0);
        end
        checkOutput("flush_len", 64'(nReset), 64'd4);
        checkOutput("armed_at", 64'(firstArmed), 64'd21);
        checkOutput("settle_veto", 64'(veto_count), 64'd1);

        // First trigger, then dead-time of 256.
        applyStimulus(1'b1, 1'b1);
        pushTrig(22, 32'd1, 42'd0, 2'd0);
        at(22); applyStimulus(1'b1, 1'b0);
        checkOutput("dead_state", 64'(state), 64'd4);
        at(26); applyStimulus(1'b1, 1'b1);
        at(27); applyStimulus(1'b1, 1'b0);

        // Two config writes in DEAD; only the last one applies, once.
        at(41); writeCfg(42'h100, 2'd2, 16'd300);
        at(51); writeCfg(42'h200, 2'd1, 16'd8);
        pushCfg(279, 32'd1, 42'h200, 2'd1);
        at(61);
        checkOutput("cfg_deferred", 64'(threshold_xc), 64'd0);

        at(121); applyStimulus(1'b1, 1'b1);
        at(122); applyStimulus(1'b1, 1'b0);
        at(123);
        checkOutput("dead_veto", 64'(veto_count), 64'd3);

        // Level held from DEAD into ARMED must not retrigger.
        at(271); applyStimulus(1'b1, 1'b1);
        at(272);
        checkOutput("level_veto", 64'(veto_count), 64'd4);
        at(277);
        checkOutput("dead_last", 64'(state), 64'd4);
        at(278);
        checkOutput("rearmed", 64'(state), 64'd3);
        at(291); applyStimulus(1'b1, 1'b0);
        checkOutput("no_level_retrig", 64'(trig_count), 64'd1);

        // Trigger beats a pending apply; dead-time now 8.
        at(301); writeCfg(THR_MAX, 2'd3, 16'd0);
        applyStimulus(1'b1, 1'b1);
        pushTrig(303, 32'd2, 42'h200, 2'd1);
        pushCfg(312, 32'd2, THR_MAX, 2'd3);
        at(303); applyStimulus(1'b1, 1'b0);

        // Dead-time 0 behaves as one cycle.
        at(321); applyStimulus(1'b1, 1'b1);
        pushTrig(322, 32'd3, THR_MAX, 2'd3);
        at(322); applyStimulus(1'b1, 1'b0);
        checkOutput("dead0_state", 64'(state), 64'd4);
        at(323);
        checkOutput("dead0_rearm", 64'(state), 64'd3);

        // Enable dropped in DEAD.
        at(331); applyStimulus(1'b1, 1'b1);
        pushTrig(332, 32'd4, THR_MAX, 2'd3);
        at(332); applyStimulus(1'b0, 1'b0);
        at(333);
        checkOutput("drop_state", 64'(state), 64'd0);
        checkOutput("drop_filt", 64'({filt_enable, filt_reset, armed}), 64'b010);
        checkOutput("drop_count", 64'(trig_count), 64'd4);

        // Re-enable, write config in FLUSH, reset in SETTLE drops it.
        applyStimulus(1'b1, 1'b0);
        at(336); writeCfg(42'h55, 2'd0, 16'd5);
        at(340);
        checkOutput("flush_cfg_held", 64'(threshold_xc), 64'(THR_MAX));
        checkOutput("settle_state", 64'(state), 64'd2);
        at(341); reset = 1'b1;
        at(342);
        checkOutput("mid_rst_state", 64'(state), 64'd0);
        checkOutput("mid_rst_cfg", 64'({threshold_xc, output_selector}), 64'd0);
        checkOutput("mid_rst_counts", 64'({trig_count, veto_count}), 64'd0);
        checkOutput("mid_rst_filt", 64'({filt_enable, filt_reset, armed}), 64'b010);
        reset = 1'b0;

        // Enable drop coinciding with an ARMED edge issues no trigger.
        at(370);
        checkOutput("rearm_after_rst", 64'(state), 64'd3);
        applyStimulus(1'b0, 1'b1);
        at(371);
        checkOutput("drop_edge_state", 64'(state), 64'd0);
        checkOutput("drop_edge_count", 64'(trig_count), 64'd0);
        applyStimulus(1'b0, 1'b0);

        at(380);
        checkOutput("trig_queue_empty", 64'(trigQ.size()), 64'd0);
        checkOutput("cfg_queue_empty", 64'(cfgQ.size()), 64'd0);
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
